sram_banked: RTL and testbench

Parametrised multi-bank single-port SRAM with byte-enable writes, a registered read port, and a valid/ready request/response handshake. After reset, a hardware sweep zero-fills every word of every bank. It replaces the flat single-bank combinational-read SRAM as the backing store for simulator-generated memory modules. Responses hold under back-pressure, so downstream pipeline stages can stall it safely.

---
 rtl/sram_banked_if.sv | 30 +++
 rtl/sram_banked.sv | 91 +++++++++
 tb/tb_sram_banked.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_banked_if.sv
// Request/response bus for sram_banked.
// The master drives requests and rsp_ready. The slave (the SRAM) drives
// req_ready and the response fields.
interface sram_banked_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned BANK_W     = 1
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [BANK_W-1:0]       req_bank;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_bank, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_bank, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sram_banked.sv
// Multi-bank single-port SRAM with byte-enable writes and a registered read port.
// After reset, a hardware sweep writes zero to every word of every bank.
// Read responses hold under back-pressure. A request to a bank code at or
// above NUM_BANKS is accepted. A write to such a bank is dropped. A read of
// such a bank returns zero data with rsp_err set.
module sram_banked #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_BANKS  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_banked_if.slave      bus,
  output logic              init_done
);
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned BE_W   = DATA_WIDTH / 8;

  // Compared against the zero-extended bank code, so every code is handled.
  localparam logic [BANK_W:0] NB_LIM = NUM_BANKS[BANK_W:0];

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ic;
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  logic                  bank_ok;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wmask;

  assign bus.req_ready = (state == ST_RUN) && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_write;
  assign wr_accept     = accept && bus.req_write;
  assign bank_ok       = ({1'b0, bus.req_bank} < NB_LIM);

  // Expand each byte-enable bit into a full byte of the write mask.
  for (genvar g = 0; g < BE_W; g++) begin : g_mask
    assign wmask[8*g+7:8*g] = {8{bus.req_be[g]}};
  end

  // Read mux. A nonexistent bank reads as zero so the array is never indexed out of range.
  always_comb begin
    rd_word = '0;
    if (bank_ok) rd_word = mem[bus.req_bank][bus.req_addr];
  end

  // Control state, sweep counter and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      ic            <= '0;
      init_done     <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        ic <= ic + 1'b1;
        if (ic == '1) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end
      if (rd_accept) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= rd_word;
        bus.rsp_err   <= !bank_ok;
      end else if (bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

  // Storage update. The sweep owns every bank during INIT.
  // Requests only reach the array once RUN is reached, because accept needs req_ready.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) mem[BANK_W'(b)][ic] <= '0;
    end else if (wr_accept && bank_ok) begin
      mem[bus.req_bank][bus.req_addr] <=
        (mem[bus.req_bank][bus.req_addr] & ~wmask) | (bus.req_wdata & wmask);
    end
  end
endmodule

// File: tb/tb_sram_banked.sv
// Directed bench for sram_banked, built with three banks of 512 words.
// Expected read responses are queued when a read is accepted. They are
// popped when the DUT hands the response over.
module tb_sram_banked;
  logic clk;
  logic rst_n;
  logic init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [3][512];
  logic [32:0] sb [$];

  sram_banked_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .BANK_W(2)) bus ();

  sram_banked #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .NUM_BANKS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response scoreboard: a response is taken on the edge after this negedge
  // whenever rsp_valid and rsp_ready are both high.
  always @(negedge clk) begin
    logic [32:0] exp_rsp;
    logic [32:0] got_rsp;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp got data=%h err=%b exp none", bus.rsp_data, bus.rsp_err);
      end
      if (sb.size() != 0) begin
        exp_rsp = sb.pop_front();
        got_rsp = {bus.rsp_err, bus.rsp_data};
        checks++;
        assert (got_rsp === exp_rsp) else begin
          errors++;
          $error("FAIL rsp got err=%b data=%h exp err=%b data=%h",
                 got_rsp[32], got_rsp[31:0], exp_rsp[32], exp_rsp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one request and wait (bounded) for it to be accepted. Returns at
  // posedge+1 after the accepting edge, so any read response is visible then.
  task automatic issue(input logic w, input logic [1:0] b, input logic [8:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int unsigned n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_bank  = b;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready) begin
      if (w) begin
        if (b < 2'd3)
          for (int i = 0; i < 4; i++)
            if (be[i]) model[b][a][8*i +: 8] = d[8*i +: 8];
      end else begin
        sb.push_back((b < 2'd3) ? {1'b0, model[b][a]} : {1'b1, 32'd0});
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_init();
    int unsigned n = 0;
    while (!init_done && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_done_wait", {31'd0, init_done}, 32'd1);
  endtask

  task automatic zero_model();
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 512; a++)
        model[b][a] = 32'd0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_bank  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    zero_model();

    // Reset values
    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data",  bus.rsp_data, 32'd0);
    chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);

    // INIT lasts 512 edges; a write driven during INIT must be ignored
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_bank  = 2'd1;
    bus.req_addr  = 9'h1FF;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_be    = 4'hF;
    for (int e = 1; e <= 512; e++) begin
      @(posedge clk); #1;
      if (e == 1 || e == 511) begin
        chk("init_req_ready_low", {31'd0, bus.req_ready}, 32'd0);
        chk("init_done_low",      {31'd0, init_done}, 32'd0);
        if (e == 511) bus.req_valid = 1'b0;
      end
      if (e == 512) begin
        chk("init_req_ready_high", {31'd0, bus.req_ready}, 32'd1);
        chk("init_done_high",      {31'd0, init_done}, 32'd1);
      end
    end
    issue(1'b0, 2'd1, 9'h1FF, 32'd0, 4'h0);
    chk("first_read_data", bus.rsp_data, 32'h0000_0000);
    issue(1'b0, 2'd2, 9'h000, 32'd0, 4'h0);
    idle(1);

    // Byte-enable merge, then a read accepted right after the write
    issue(1'b1, 2'd0, 9'd5, 32'hAABB_CCDD, 4'hF);
    issue(1'b1, 2'd0, 9'd5, 32'h1122_3344, 4'h5);
    issue(1'b0, 2'd0, 9'd5, 32'd0, 4'h0);
    chk("be_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("be_rsp_data",  bus.rsp_data, 32'hAA22_CC44);
    chk("be_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
    // be=0 is a no-op write
    issue(1'b1, 2'd0, 9'd5, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 2'd0, 9'd5, 32'd0, 4'h0);
    idle(1);
    chk("clear_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("clear_keeps_data", bus.rsp_data, 32'hAA22_CC44);

    // Back-pressure: the response holds and req_ready stays low
    issue(1'b1, 2'd2, 9'h100, 32'h1234_5678, 4'hF);
    bus.rsp_ready = 1'b0;
    issue(1'b0, 2'd2, 9'h100, 32'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_data",  bus.rsp_data, 32'h1234_5678);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      idle(1);
    end
    bus.rsp_ready = 1'b1;
    issue(1'b0, 2'd0, 9'd5, 32'd0, 4'h0);
    chk("bp_second_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_second_data",  bus.rsp_data, 32'hAA22_CC44);
    idle(1);

    // Streaming: 8 writes, then 8 back-to-back reads
    for (int i = 0; i < 8; i++)
      issue(1'b1, 2'd1, 9'(i * 3), 32'hC0DE_0000 ^ (32'h0101_0101 * i), 4'hF);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 2'd1, 9'(i * 3), 32'd0, 4'h0);
      chk("stream_valid", {31'd0, bus.rsp_valid}, 32'd1);
    end
    idle(1);
    chk("stream_end_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Invalid bank: a write is dropped and a read returns an error
    issue(1'b1, 2'd3, 9'd7, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 2'd3, 9'd7, 32'd0, 4'h0);
    chk("badbank_err",  {31'd0, bus.rsp_err}, 32'd1);
    chk("badbank_data", bus.rsp_data, 32'd0);
    issue(1'b0, 2'd0, 9'd7, 32'd0, 4'h0);
    chk("goodbank_err", {31'd0, bus.rsp_err}, 32'd0);
    issue(1'b0, 2'd1, 9'd7, 32'd0, 4'h0);
    issue(1'b0, 2'd2, 9'd7, 32'd0, 4'h0);
    idle(1);

    // Reset mid-operation with a response outstanding
    bus.rsp_ready = 1'b0;
    issue(1'b0, 2'd0, 9'd5, 32'd0, 4'h0);
    chk("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",     {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_data",      bus.rsp_data, 32'd0);
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    sb.delete();
    zero_model();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();
    issue(1'b0, 2'd0, 9'd5, 32'd0, 4'h0);
    chk("post_rst_word", bus.rsp_data, 32'd0);
    issue(1'b0, 2'd2, 9'h100, 32'd0, 4'h0);
    issue(1'b0, 2'd1, 9'd3, 32'd0, 4'h0);
    idle(3);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
